// File: rtl/maze_pkg.sv
// Purpose: shared key indices, debounce FSM state encoding and counter sizing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maze_pkg;

  localparam int N_KEYS    = 5;

  localparam int KEY_START = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_LEFT  = 3;
  localparam int KEY_RIGHT = 4;

  // Every key auto-repeats except start, which must fire once per press.
  localparam logic [N_KEYS-1:0] REPEAT_MASK_DEFAULT = ~(N_KEYS'(1) << KEY_START);

  typedef enum logic [2:0] {
    WAIT_REL,
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_REL
  } kstate_t;

  // Counter width large enough to hold (largest timing parameter - 1); never below 1.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// Purpose: one key - 2-FF synchroniser, debounce FSM with hold auto-repeat, level + 1-cycle request.
// Latency: raw edge -> req/level = 2 (sync) + DEBOUNCE_CYCLES cycles.
// Backpressure: none; req is a single-cycle strobe, the arbiter above must latch it.
module key_debounce_fsm
  import maze_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic req
);

  // Terminal counts. The cycle in which IDLE/HELD first sees the new level counts as the
  // first stable sample, so DEB_PRESS/DEB_REL finish when the incremented count hits DEB_LAST.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam bit               RPT_ON   = REPEAT_EN && (REPEAT_DELAY > 0);

  logic             sync_meta;
  logic             sync;
  kstate_t          state;
  kstate_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] rpt_last;
  logic             rpt_phase;
  logic             rpt_phase_nxt;
  logic             level_nxt;
  logic             req_nxt;

  // Two-flop synchroniser for the asynchronous, bouncing button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= key_raw;
      sync      <= sync_meta;
    end
  end

  // FSM state, stability/repeat counter, repeat-phase flag and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_REL;
      cnt       <= '0;
      rpt_phase <= 1'b0;
      level     <= 1'b0;
      req       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rpt_phase <= rpt_phase_nxt;
      level     <= level_nxt;
      req       <= req_nxt;
    end
  end

  // Next-state and output decode; the counter saturates rather than wrapping.
  always_comb begin
    cnt_inc       = (cnt == '1) ? cnt : cnt + 1'b1;
    rpt_last      = rpt_phase ? PER_LAST : DLY_LAST;
    state_nxt     = state;
    cnt_nxt       = cnt_inc;
    rpt_phase_nxt = rpt_phase;
    level_nxt     = level;
    req_nxt       = 1'b0;

    case (state)
      // Out of reset a key must be seen released for a full window, so a key held
      // through reset never produces a press.
      WAIT_REL: begin
        if (sync) begin
          cnt_nxt = '0;
        end else if (cnt >= DEB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end

      IDLE: begin
        cnt_nxt       = '0;
        rpt_phase_nxt = 1'b0;
        if (sync) begin
          state_nxt = DEB_PRESS;
        end
      end

      DEB_PRESS: begin
        if (!sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt_inc >= DEB_LAST) begin
          state_nxt     = HELD;
          cnt_nxt       = '0;
          rpt_phase_nxt = 1'b0;
          level_nxt     = 1'b1;
          req_nxt       = 1'b1;
        end
      end

      // First repeat after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
      HELD: begin
        if (!sync) begin
          state_nxt = DEB_REL;
          cnt_nxt   = '0;
        end else if (RPT_ON && (cnt == rpt_last)) begin
          req_nxt       = 1'b1;
          cnt_nxt       = '0;
          rpt_phase_nxt = 1'b1;
        end
      end

      // A bounce back to 1 returns to HELD keeping the repeat phase; timing restarts.
      DEB_REL: begin
        if (sync) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt_inc >= DEB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = WAIT_REL;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_pulse_conditioner.sv
// Purpose: conditions start + direction buttons into one-hot-or-zero single-cycle move pulses.
// Latency: raw edge -> key_pulse = 2 + DEBOUNCE_CYCLES + 1 cycles when uncontested.
// Backpressure: none downstream; contending requests wait in pending, lowest index first, none dropped.
module key_pulse_conditioner #(
  parameter int                  N_KEYS          = maze_pkg::N_KEYS,
  parameter int                  DEBOUNCE_CYCLES = 1_000_000,
  parameter int                  REPEAT_DELAY    = 25_000_000,
  parameter int                  REPEAT_PERIOD   = 10_000_000,
  parameter logic [N_KEYS-1:0]   REPEAT_MASK     = maze_pkg::REPEAT_MASK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_pulse,
  output logic [N_KEYS-1:0] key_level,
  output logic              any_pulse
);

  localparam int CNT_W = maze_pkg::cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  logic [N_KEYS-1:0] req;
  logic [N_KEYS-1:0] pending;
  logic [N_KEYS-1:0] req_all;
  logic [N_KEYS-1:0] grant;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i]),
      .CNT_W           (CNT_W)
    ) u_key (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key_in[i]),
      .level   (key_level[i]),
      .req     (req[i])
    );
  end

  // Fixed-priority pick over waiting and fresh requests; a fresh request on an
  // already-waiting key merges into the same single pulse.
  always_comb begin
    req_all = pending | req;
    grant   = req_all & (~req_all + 1'b1);
  end

  // Pending bookkeeping and registered pulse outputs; reset drops anything outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      key_pulse <= '0;
      any_pulse <= 1'b0;
    end else begin
      pending   <= req_all & ~grant;
      key_pulse <= grant;
      any_pulse <= |grant;
    end
  end

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Purpose: directed check of debounce, auto-repeat, arbitration and reset behaviour.
// Latency: expected pulse cycles are hand-derived from the 2 + 4 + 1 path.
// Backpressure: n/a.
module tb_key_pulse_conditioner;
  import maze_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] key_in;
  logic [4:0] key_pulse;
  logic [4:0] key_level;
  logic       any_pulse;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int any_cnt  = 0;
  int t0;
  int t1;
  int tr;

  int         log_cyc[$];
  logic [4:0] log_val[$];
  int         exp_cyc[$];
  logic [4:0] exp_val[$];

  key_pulse_conditioner #(
    .N_KEYS          (5),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .REPEAT_MASK     (5'b11110)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_pulse (key_pulse),
    .key_level (key_level),
    .any_pulse (any_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-cycle invariants and pulse log, sampled 1 ns after the edge.
  always @(posedge clk) begin
    #1;
    chk("onehot0", 32'($onehot0(key_pulse)), 32'd1);
    chk("any_or", 32'(any_pulse), 32'(|key_pulse));
    if (any_pulse) any_cnt++;
    if (key_pulse != 5'b0) begin
      log_cyc.push_back(cyc);
      log_val.push_back(key_pulse);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input int c, input logic [4:0] v);
    exp_cyc.push_back(c);
    exp_val.push_back(v);
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_val.delete();
    exp_cyc.delete();
    exp_val.delete();
    any_cnt = 0;
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 32'(log_cyc.size()), 32'(exp_cyc.size()));
    for (int i = 0; i < exp_cyc.size(); i++) begin
      if (i < log_cyc.size()) begin
        chk({tag, "_cyc"}, 32'(log_cyc[i]), 32'(exp_cyc[i]));
        chk({tag, "_val"}, 32'(log_val[i]), 32'(exp_val[i]));
      end
    end
    clear_log();
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    key_in = 5'b0;
    step(3);
    chk("rst_pulse", 32'(key_pulse), 32'd0);
    chk("rst_level", 32'(key_level), 32'd0);
    chk("rst_any", 32'(any_pulse), 32'd0);
    rst = 1'b0;
    step(10);
    clear_log();

    // 1: clean press of up, held, two auto-repeats, then release.
    t0 = cyc;
    key_in[KEY_UP] = 1'b1;
    step(5);
    chk("t1_level_pre", 32'(key_level[KEY_UP]), 32'd0);
    step(1);
    chk("t1_level_rise", 32'(key_level[KEY_UP]), 32'd1);
    step(32);
    key_in[KEY_UP] = 1'b0;
    tr = cyc;
    expect_pulse(t0 + 7, 5'b00010);
    expect_pulse(t0 + 27, 5'b00010);
    expect_pulse(t0 + 35, 5'b00010);
    step(5);
    chk("t1_level_hold", 32'(key_level[KEY_UP]), 32'd1);
    step(1);
    chk("t1_level_fall", 32'(key_level[KEY_UP]), 32'd0);
    chk("t1_rel_at", 32'(cyc - tr), 32'd6);
    step(10);
    check_log("t1");

    // 2: bouncing down key, then stable high.
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      key_in[KEY_DOWN] = (i % 2 == 0);
      step(2);
    end
    key_in[KEY_DOWN] = 1'b1;
    expect_pulse(t0 + 27, 5'b00100);
    step(10);
    chk("t2_level", 32'(key_level[KEY_DOWN]), 32'd1);
    step(10);
    key_in[KEY_DOWN] = 1'b0;
    step(15);
    check_log("t2");

    // 3: left and right rise together.
    t0 = cyc;
    key_in = 5'b11000;
    expect_pulse(t0 + 7, 5'b01000);
    expect_pulse(t0 + 8, 5'b10000);
    step(15);
    key_in = 5'b0;
    step(15);
    chk("t3_any_cycles", 32'(any_cnt), 32'd2);
    check_log("t3");

    // 4: start held through reset, then released and pressed again.
    key_in[KEY_START] = 1'b1;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    chk("t4_level_rst", 32'(key_level), 32'd0);
    step(20);
    chk("t4_level_held", 32'(key_level[KEY_START]), 32'd0);
    key_in[KEY_START] = 1'b0;
    step(10);
    t0 = cyc;
    key_in[KEY_START] = 1'b1;
    expect_pulse(t0 + 7, 5'b00001);
    step(45);
    chk("t4_level_press", 32'(key_level[KEY_START]), 32'd1);
    key_in[KEY_START] = 1'b0;
    step(15);
    check_log("t4");

    // 5: reset while up repeats and down's first pulse is waiting behind it.
    t0 = cyc;
    key_in[KEY_UP] = 1'b1;
    step(28);
    key_in[KEY_DOWN] = 1'b1;
    step(7);
    chk("t5_level_pre", 32'(key_level), 32'b00110);
    rst = 1'b1;
    step(1);
    chk("t5_rst_pulse", 32'(key_pulse), 32'd0);
    chk("t5_rst_level", 32'(key_level), 32'd0);
    chk("t5_rst_any", 32'(any_pulse), 32'd0);
    rst = 1'b0;
    expect_pulse(t0 + 7, 5'b00010);
    expect_pulse(t0 + 27, 5'b00010);
    expect_pulse(t0 + 35, 5'b00010);
    step(40);
    chk("t5_level_held", 32'(key_level), 32'd0);
    key_in = 5'b0;
    step(10);
    t1 = cyc;
    key_in[KEY_UP] = 1'b1;
    expect_pulse(t1 + 7, 5'b00010);
    step(12);
    key_in = 5'b0;
    step(15);
    check_log("t5");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
